lpif_tx_beat_packer: RTL
========================

Name: lpif_tx_beat_packer

Overview:
Upstream neighbour of the PCIe physical-layer TX top. It accepts a 32-bit DW stream of TLPs and DLLPs from the data link layer and packs it into 512-bit LPIF beats. It drives lp_data, lp_valid, the start/end byte markers and lp_irdy, and obeys pl_trdy backpressure. Each packet starts at byte 0 of a fresh beat. A beat is emitted when it holds 16 DWs or when the packet ends.

Parameters:
BEAT_DW, 16, DWs per LPIF beat (64 bytes; lp_* widths are fixed at 512/64 bits).
CNT_W, 16, width of the accepted-packet counter.

Ports:
pclk  in  1  clock.
reset  in  1  synchronous, active-high reset.
dl_data  in  32  packet DW; byte 0 is dl_data[7:0] and goes first on the link.
dl_valid  in  1  dl_data is valid.
dl_sop  in  1  DW is the first of a packet.
dl_eop  in  1  DW is the last of a packet; may coincide with dl_sop.
dl_is_dllp  in  1  packet type, sampled with dl_sop: 1 = DLLP, 0 = TLP.
dl_ready  out  1  packer accepts a DW this cycle.
lp_irdy  out  1  beat on lp_* is valid.
pl_trdy  in  1  TX accepts the beat; a transfer occurs when lp_irdy & pl_trdy.
lp_data  out  512  beat payload; byte i is lp_data[8i+:8].
lp_valid  out  64  per-byte valid.
lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend  out  64 each  per-byte packet markers.
pkt_count  out  CNT_W  number of packets accepted through eop; wraps.
proto_err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (sync, active-high): all outputs are 0 except dl_ready = 1. State = IDLE, wptr = 0, assembly buffer and output register are cleared, pending = 0.
- Accept condition: dl_valid & dl_ready. The accepted DW is written to assembly slot wptr (bytes 4*wptr .. 4*wptr+3) and those 4 lp_valid bits are set.
- Markers, by dl_is_dllp latched at sop:
  - sop DW: the start bit of byte 4*wptr is set (tlpstart or dlpstart).
  - eop DW: the end bit of byte 4*wptr+3 is set.
- States:
  - IDLE: accepted DW with sop -> IN_PKT, or stays IDLE if eop is also set.
  - IN_PKT: eop -> IDLE.
- Beat completion: an accepted DW with eop, or wptr == BEAT_DW-1, completes the beat.
  - The beat is "out-free" if the output register is empty or transfers this cycle.
  - If out-free: the completed beat (including the incoming DW) loads into the output register at the same edge. The assembly buffer clears and wptr = 0.
  - Otherwise: the beat stays in the assembly buffer with pending = 1. It moves on the first out-free cycle, then pending clears.
- dl_ready = !pending. This is combinational from registers only; there is no combinational path from dl_valid.
- Latency: an eop or 16th DW accepted in cycle N gives lp_irdy = 1 in N+1 when the output register is free. Peak throughput is 16 DW per beat with no bubble.
- lp_irdy and lp_* hold stable until a transfer occurs. After a transfer with no new load, lp_irdy = 0 and all lp_* are 0.
- Multi-beat packets: a mid-packet full beat carries a start marker only if the sop fell in it, and no end marker. The next beat continues at slot 0.
- pkt_count increments by 1 on each accepted eop and wraps at 2^CNT_W.
- Framing violations:
  - DW without sop in IDLE: the DW is dropped (still acknowledged by dl_ready) and proto_err pulses.
  - sop in IN_PKT: proto_err pulses, the partial assembly buffer is discarded, and the DW starts a new packet at slot 0. A pending full beat is never discarded, because dl_ready = 0 blocks input while pending.
- Reset mid-packet or mid-beat: every buffered beat is lost and no partial beat is emitted.

Test Plan:
- Single 3-DW TLP (0x11111111, 0x22222222, 0x33333333), pl_trdy = 1 -> one beat next cycle after eop. lp_valid = 0x0000_0000_0000_0FFF, lp_tlpstart bit 0, lp_tlpend bit 11, pkt_count = 1.
- 2-DW DLLP with dl_sop and dl_eop on separate DWs -> lp_dlpstart bit 0, lp_dlpend bit 7, lp_valid = 0xFF, TLP markers all 0.
- 20-DW TLP with pl_trdy = 1 -> beat 1: lp_valid all 1, tlpstart bit 0, no end. Beat 2: lp_valid = 0xFFFF, tlpend bit 15, no start.
- pl_trdy = 0 for 40 cycles during back-to-back 4-DW TLPs -> the first beat holds stable and dl_ready drops after the second eop. On release, beats emerge in order with none lost; pkt_count = accepted eops.
- DW with no sop in IDLE -> proto_err 1 cycle and no beat. Sop in IN_PKT after 2 DWs -> proto_err, and the next beat contains only the new packet starting at byte 0.
- Assert reset after 5 DWs of a packet -> next cycle lp_irdy = 0, dl_ready = 1, pkt_count = 0. A following clean packet is emitted correctly.

Source files
------------

// File: rtl/lpif_tx_beat_packer_if.sv
// Handshake bundle between the DL-layer DW stream, the packer and the LPIF TX.
// slave = the packer's view, master = the neighbours driving it.
interface lpif_tx_beat_packer_if;
  logic [31:0]  dl_data;
  logic         dl_valid;
  logic         dl_sop;
  logic         dl_eop;
  logic         dl_is_dllp;
  logic         dl_ready;
  logic         lp_irdy;
  logic         pl_trdy;
  logic [511:0] lp_data;
  logic [63:0]  lp_valid;
  logic [63:0]  lp_tlpstart;
  logic [63:0]  lp_tlpend;
  logic [63:0]  lp_dlpstart;
  logic [63:0]  lp_dlpend;

  modport slave (
    input  dl_data, dl_valid, dl_sop, dl_eop, dl_is_dllp, pl_trdy,
    output dl_ready, lp_irdy, lp_data, lp_valid,
           lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend
  );

  modport master (
    output dl_data, dl_valid, dl_sop, dl_eop, dl_is_dllp, pl_trdy,
    input  dl_ready, lp_irdy, lp_data, lp_valid,
           lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend
  );
endinterface

// File: rtl/lpif_tx_beat_packer.sv
// Packs a 32-bit DW stream of TLPs/DLLPs into 512-bit LPIF beats.
// One assembly buffer plus one output register; a completed beat that cannot
// enter the output register parks in the assembly buffer (pending) and stalls
// the DW input until it moves.
module lpif_tx_beat_packer #(
  parameter int BEAT_DW = 16,
  parameter int CNT_W   = 16
) (
  input  logic               pclk,
  input  logic               reset,
  lpif_tx_beat_packer_if.slave bus,
  output logic [CNT_W-1:0]   pkt_count,
  output logic               proto_err
);

  localparam logic [3:0] LAST_SLOT = 4'(BEAT_DW - 1);

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  valid;
    logic [63:0]  tstart;
    logic [63:0]  tend;
    logic [63:0]  dstart;
    logic [63:0]  dend;
  } beat_t;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       wptr_q, wptr_d;
  beat_t            asm_q, asm_d;
  beat_t            out_q, out_d;
  logic             irdy_q, irdy_d;
  logic             pending_q, pending_d;
  logic             dllp_q, dllp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             xfer, out_free, acc, typ;
  logic [3:0]       slot;
  beat_t            wbeat;

  // Next-state: output drain, pending move, DW accept/write and beat completion
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    asm_d     = asm_q;
    out_d     = out_q;
    irdy_d    = irdy_q;
    pending_d = pending_q;
    dllp_d    = dllp_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    wbeat     = asm_q;
    slot      = wptr_q;
    typ       = dllp_q;

    xfer     = irdy_q & bus.pl_trdy;
    out_free = !irdy_q | bus.pl_trdy;
    acc      = bus.dl_valid & !pending_q;

    // A transfer empties the output register unless something reloads it below
    if (xfer) begin
      out_d  = '0;
      irdy_d = 1'b0;
    end

    if (pending_q) begin
      if (out_free) begin
        out_d     = asm_q;
        irdy_d    = 1'b1;
        asm_d     = '0;
        pending_d = 1'b0;
      end
    end else if (acc) begin
      if (state_q == IDLE && !bus.dl_sop) begin
        // Stray DW outside a packet: acknowledged and dropped
        err_d = 1'b1;
      end else begin
        if (bus.dl_sop) begin
          typ    = bus.dl_is_dllp;
          dllp_d = bus.dl_is_dllp;
          // Restart mid-packet: throw away the partial beat, begin at slot 0
          if (state_q == IN_PKT) begin
            err_d = 1'b1;
            wbeat = '0;
            slot  = 4'd0;
          end
        end
        wbeat.data[{slot, 5'd0} +: 32] = bus.dl_data;
        wbeat.valid[{slot, 2'd0} +: 4] = 4'hF;
        if (bus.dl_sop) begin
          if (typ) wbeat.dstart[{slot, 2'd0}] = 1'b1;
          else     wbeat.tstart[{slot, 2'd0}] = 1'b1;
        end
        if (bus.dl_eop) begin
          if (typ) wbeat.dend[{slot, 2'd3}] = 1'b1;
          else     wbeat.tend[{slot, 2'd3}] = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
        state_d = bus.dl_eop ? IDLE : IN_PKT;

        if (bus.dl_eop || slot == LAST_SLOT) begin
          wptr_d = 4'd0;
          if (out_free) begin
            out_d  = wbeat;
            irdy_d = 1'b1;
            asm_d  = '0;
          end else begin
            asm_d     = wbeat;
            pending_d = 1'b1;
          end
        end else begin
          asm_d  = wbeat;
          wptr_d = slot + 4'd1;
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q   <= IDLE;
      wptr_q    <= 4'd0;
      asm_q     <= '0;
      out_q     <= '0;
      irdy_q    <= 1'b0;
      pending_q <= 1'b0;
      dllp_q    <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      asm_q     <= asm_d;
      out_q     <= out_d;
      irdy_q    <= irdy_d;
      pending_q <= pending_d;
      dllp_q    <= dllp_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.dl_ready    = !pending_q;
  assign bus.lp_irdy     = irdy_q;
  assign bus.lp_data     = out_q.data;
  assign bus.lp_valid    = out_q.valid;
  assign bus.lp_tlpstart = out_q.tstart;
  assign bus.lp_tlpend   = out_q.tend;
  assign bus.lp_dlpstart = out_q.dstart;
  assign bus.lp_dlpend   = out_q.dend;
  assign pkt_count       = cnt_q;
  assign proto_err       = err_q;

endmodule
